// File: rtl/muldiv32.sv
// muldiv32: iterative multiply/divide unit that owns the HI/LO register pair.
// It runs MULT/MULTU as shift-add and DIV/DIVU as restoring division.
// Each operation takes one bit per cycle, followed by a sign fix-up cycle.
module muldiv32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  // Operand signed views; op[0]=0 selects the signed variants (MULT, DIV).
  logic signed [WIDTH-1:0] num1_s, num2_s;
  logic                    op_signed, launch, div_by_zero;

  // Datapath state: no reset needed, every field is loaded at launch.
  logic                 is_div, sign1, sign2;
  logic [WIDTH-1:0]     mcand;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0]   acc;        // product accumulator; low half is the quotient for div
  logic [WIDTH:0]       rem;        // partial remainder

  // Per-iteration step values and fix-up results.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH+1:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, fix_hi, fix_lo;

  // Magnitude of a possibly signed operand.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (is_signed && v[WIDTH-1]) ? n : v;
  endfunction

  // Conditional two's-complement negation, single width.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional two's-complement negation, double width.
  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign num1_s      = num1;
  assign num2_s      = num2;
  assign op_signed   = ~op[0];
  assign launch      = (state == IDLE) && start;
  assign div_by_zero = op[1] && (num2 == '0);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = div_by_zero ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, iteration counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC) || (state_next == FIX);
      done  <= (state_next == DONE);
      if (state == CALC) cnt <= cnt + CNT_W'(1);
      else               cnt <= '0;
      if (launch) div_zero <= div_by_zero;
    end
  end

  // One shift-add step and one restoring-division step.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {2'b00, mcand};
  end

  // Sign fix-up of the finished product or quotient/remainder.
  always_comb begin
    prod_fix = cond_neg_wide(acc, sign1 ^ sign2);
    quo_fix  = cond_neg(acc[WIDTH-1:0], sign1 ^ sign2);
    rem_fix  = cond_neg(rem[WIDTH-1:0], sign1);
    fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Operand latch at launch, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (launch) begin
      is_div <= op[1];
      sign1  <= op_signed && num1[WIDTH-1];
      sign2  <= op_signed && num2[WIDTH-1];
      rem    <= '0;
      if (op[1]) begin
        mcand <= magnitude(num2_s, op_signed);
        acc   <= {{WIDTH{1'b0}}, magnitude(num1_s, op_signed)};
      end else begin
        mcand <= magnitude(num1_s, op_signed);
        acc   <= {{WIDTH{1'b0}}, magnitude(num2_s, op_signed)};
      end
    end else if (state == CALC) begin
      if (is_div) begin
        if (!div_diff[WIDTH+1]) begin
          rem             <= div_diff[WIDTH:0];
          acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
        end else begin
          rem             <= div_shift[WIDTH:0];
          acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= mul_next;
      end
    end
  end

  // HI/LO: direct writes only while idle, results committed in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv32.sv
// Bench for muldiv32: directed operations, a cycle-level behavioural model
// compared every cycle, and literal expected results per operation.
module tb_muldiv32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] num1 = '0, num2 = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  muldiv32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Arithmetic result {hi,lo} of an operation, from plain 64-bit math.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x, y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: begin q = sx * sy; return q; end
      2'b01: begin p = ux * uy; return p; end
      2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: return {x % y, x / y};
    endcase
  endfunction

  // Behavioural model: idle / busy countdown / done cycle.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done, m_dz, m_in_done;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; m_dz <= 0;
      m_in_done <= 0; m_left <= 0;
    end else if (m_in_done) begin
      m_in_done <= 0;
      m_done    <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_busy <= 0; m_done <= 1; m_in_done <= 1;
      end
    end else begin
      if (hi_we) m_hi <= wdata;
      if (lo_we) m_lo <= wdata;
      if (start) begin
        if (op[1] && num2 == 0) begin
          m_dz <= 1; m_done <= 1; m_in_done <= 1;
        end else begin
          m_dz <= 0;
          {p_hi, p_lo} <= model_result(op, num1, num2);
          m_left <= 33;
          m_busy <= 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({busy, done, div_zero, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t busy/done/dz/hi/lo actual %b %b %b %h %h expected %b %b %b %h %h",
                 $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; op = o; num1 = a; num2 = b;
    @(negedge clk);
    start = 0; num1 = 32'hA5A5_5A5A; num2 = 32'h0F0F_F0F0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int exp_cyc,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    go(o, a, b);
    wait_done(cyc);
    chk({name, "_latency"}, cyc, exp_cyc);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 0;
    check_en = 1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_flags", {29'b0, busy, done, div_zero}, 0);

    run("multu_7x6", 2'b01, 32'd7, 32'd6, 34, 32'h0, 32'd42);
    chk("multu_7x6_dz", {31'b0, div_zero}, 0);
    run("mult_m1x3", 2'b00, 32'hFFFF_FFFF, 32'd3, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_100d7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14);
    run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);

    // Direct LO write, then divide by zero leaves HI/LO alone.
    @(negedge clk);
    lo_we = 1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 0; wdata = 0;
    run("divu_zero", 2'b11, 32'd55, 32'd0, 1, 32'h0, 32'h1234);
    chk("divu_zero_flag", {31'b0, div_zero}, 1);
    repeat (3) @(negedge clk);
    chk("dz_hold", {31'b0, div_zero}, 1);

    // Start during CALC is ignored.
    go(2'b00, 32'd5, 32'hFFFF_FFFE);
    chk("dz_cleared", {31'b0, div_zero}, 0);
    repeat (9) @(negedge clk);
    start = 1; op = 2'b11; num1 = 32'd9; num2 = 32'd3;
    @(negedge clk);
    start = 0;
    wait_done(cyc);
    chk("restart_ignored_hi", hi, 32'hFFFF_FFFF);
    chk("restart_ignored_lo", lo, 32'hFFFF_FFF6);

    // HI write during CALC is ignored.
    go(2'b01, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    hi_we = 1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 0; wdata = 0;
    chk("hi_we_busy_hold", hi, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("hi_we_busy_hi", hi, 32'h0);
    chk("hi_we_busy_lo", lo, 32'd12);

    // Reset in the middle of a DIVU.
    go(2'b11, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("midrst_no_done", {31'b0, seen}, 0);

    run("div_after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
